vram_ctrl: RTL and testbench



---
 rtl/vram_ctrl_pkg.sv | 20 ++
 rtl/vram_ctrl_dpram.sv | 50 +++++
 rtl/vram_ctrl.sv | 122 ++++++++++++
 tb/tb_vram_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_ctrl_pkg.sv
// Shared definitions for the character VRAM: controller states, screen geometry and fill byte.
// Geometry constants are also consumed by the VGA text generator.
package vram_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } vram_state_e;

    localparam int unsigned COLS = 64;
    localparam int unsigned ROWS = 16;

    localparam logic [7:0] FILL_DEFAULT = 8'h20;

    // Model I 7-bit VRAM: bit 6 is not a real cell, it is derived from bits 5 and 7.
    function automatic logic [7:0] fold_bit6(input logic [7:0] d);
        return {d[7], ~(d[5] | d[7]), d[5:0]};
    endfunction

endpackage

// File: rtl/vram_ctrl_dpram.sv
// Generic true dual-port RAM with registered reads on both ports (maps to one ECP5 DP16KD).
// Port A is read-only; port B reads or writes, with write-through on a simultaneous read.
module vram_ctrl_dpram #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 1024,
    parameter string       MEM_INIT_FILE = "",
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    addr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    addr_b_i,
    input  logic             we_b_i,
    input  logic             re_b_i,
    input  logic [WIDTH-1:0] wdata_b_i,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

    // Port A read sees the pre-write contents on a same-address port B write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a_q <= '0;
        end else begin
            rdata_a_q <= mem[addr_a_i];
        end
    end

    always_ff @(posedge clk) begin
        if (we_b_i) begin
            mem[addr_b_i] <= wdata_b_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_b_q <= '0;
        end else if (re_b_i) begin
            rdata_b_q <= we_b_i ? wdata_b_i : mem[addr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/vram_ctrl.sv
// Character VRAM for the 64x16 text display: video read port, CPU port with wait handshake,
// and a fill engine that clears the screen on reset or on request.
module vram_ctrl
    import vram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = $clog2(COLS * ROWS),
    parameter logic [7:0]  FILL           = FILL_DEFAULT,
    parameter bit          LOWERCASE      = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter string       MEM_INIT_FILE  = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] vga_addr_i,
    output logic [7:0]           vga_data_o,
    input  logic [ADDR_BITS-1:0] cpu_addr_i,
    input  logic [7:0]           cpu_din_i,
    input  logic                 cpu_wr_i,
    input  logic                 cpu_rd_i,
    output logic [7:0]           cpu_dout_o,
    output logic                 cpu_wait_o,
    input  logic                 clr_req_i,
    output logic                 clr_busy_o
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    // Bit 6 is resolved at write time, so stored bytes already read back in final form and
    // the registered read data needs no post-processing (and resets to zero).
    localparam logic [7:0] FillStored = LOWERCASE ? FILL : fold_bit6(FILL);

    vram_state_e          state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;

    logic [ADDR_BITS-1:0] b_addr;
    logic                 b_we;
    logic                 b_re;
    logic [7:0]           b_wdata;
    logic [7:0]           cpu_wdata;

    assign cpu_wdata = LOWERCASE ? cpu_din_i : fold_bit6(cpu_din_i);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; clr_req is only honoured from idle, so a fill never restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_BITS'(1);
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs and port-B ownership.
    always_comb begin
        b_addr     = cpu_addr_i;
        b_we       = 1'b0;
        b_re       = 1'b0;
        b_wdata    = cpu_wdata;
        clr_busy_o = 1'b0;
        cpu_wait_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                b_we = cpu_wr_i & ~reset;
                b_re = cpu_rd_i & ~reset;
            end
            ST_CLEAR: begin
                b_addr     = cnt_q;
                b_wdata    = FillStored;
                b_we       = ~reset;
                clr_busy_o = 1'b1;
                cpu_wait_o = cpu_rd_i | cpu_wr_i;
            end
            default: begin
                b_we = 1'b0;
            end
        endcase
    end

    vram_ctrl_dpram #(
        .WIDTH        (8),
        .DEPTH        (Depth),
        .MEM_INIT_FILE(MEM_INIT_FILE)
    ) u_dpram (
        .clk      (clk),
        .reset    (reset),
        .addr_a_i (vga_addr_i),
        .rdata_a_o(vga_data_o),
        .addr_b_i (b_addr),
        .we_b_i   (b_we),
        .re_b_i   (b_re),
        .wdata_b_i(b_wdata),
        .rdata_b_o(cpu_dout_o)
    );

    idle_never_waits: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_IDLE) |-> !cpu_wait_o);

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl: default build (A) and a 7-bit, no-auto-clear build (B).
module tb_vram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: defaults
    logic       rst_a = 1'b1;
    logic [9:0] a_vga_addr = '0;
    logic [7:0] a_vga_data;
    logic [9:0] a_cpu_addr = '0;
    logic [7:0] a_cpu_din = '0;
    logic       a_cpu_wr = 1'b0;
    logic       a_cpu_rd = 1'b0;
    logic [7:0] a_cpu_dout;
    logic       a_cpu_wait;
    logic       a_clr_req = 1'b0;
    logic       a_clr_busy;

    // DUT B: LOWERCASE = 0, CLEAR_ON_RESET = 0
    logic       rst_b = 1'b1;
    logic [9:0] b_vga_addr = '0;
    logic [7:0] b_vga_data;
    logic [9:0] b_cpu_addr = '0;
    logic [7:0] b_cpu_din = '0;
    logic       b_cpu_wr = 1'b0;
    logic       b_cpu_rd = 1'b0;
    logic [7:0] b_cpu_dout;
    logic       b_cpu_wait;
    logic       b_clr_req = 1'b0;
    logic       b_clr_busy;

    vram_ctrl u_dut_a (
        .clk       (clk),
        .reset     (rst_a),
        .vga_addr_i(a_vga_addr),
        .vga_data_o(a_vga_data),
        .cpu_addr_i(a_cpu_addr),
        .cpu_din_i (a_cpu_din),
        .cpu_wr_i  (a_cpu_wr),
        .cpu_rd_i  (a_cpu_rd),
        .cpu_dout_o(a_cpu_dout),
        .cpu_wait_o(a_cpu_wait),
        .clr_req_i (a_clr_req),
        .clr_busy_o(a_clr_busy)
    );

    vram_ctrl #(
        .LOWERCASE     (1'b0),
        .CLEAR_ON_RESET(1'b0)
    ) u_dut_b (
        .clk       (clk),
        .reset     (rst_b),
        .vga_addr_i(b_vga_addr),
        .vga_data_o(b_vga_data),
        .cpu_addr_i(b_cpu_addr),
        .cpu_din_i (b_cpu_din),
        .cpu_wr_i  (b_cpu_wr),
        .cpu_rd_i  (b_cpu_rd),
        .cpu_dout_o(b_cpu_dout),
        .cpu_wait_o(b_cpu_wait),
        .clr_req_i (b_clr_req),
        .clr_busy_o(b_clr_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic       wr;
        logic       rd;
        logic [9:0] addr;
        logic [7:0] din;
        logic [7:0] exp_dout;
    } vec_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } lc_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [7:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [7:0] act);
        sb_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got %0h want queued entry", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h want %0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic vga_a(input logic [9:0] addr, input logic [7:0] exp);
        a_vga_addr = addr;
        sb_push($sformatf("vga_a_%0h", addr), exp);
        tick();
        sb_check(a_vga_data);
    endtask

    task automatic vga_b(input logic [9:0] addr, input logic [7:0] exp);
        b_vga_addr = addr;
        sb_push($sformatf("vga_b_%0h", addr), exp);
        tick();
        sb_check(b_vga_data);
    endtask

    vec_t    vecs[8];
    lc_vec_t lc_vecs[6];

    initial begin
        int cyc;
        int wait_hi;
        logic [9:0] sa;
        logic [7:0] se;

        vecs[0] = '{1'b1, 1'b0, 10'h041, 8'h5A, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 10'h041, 8'h00, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 10'h3FF, 8'hA5, 8'h5A};
        vecs[3] = '{1'b0, 1'b1, 10'h3FF, 8'h00, 8'hA5};
        vecs[4] = '{1'b1, 1'b1, 10'h200, 8'h33, 8'h33};
        vecs[5] = '{1'b1, 1'b0, 10'h100, 8'h77, 8'h33};
        vecs[6] = '{1'b0, 1'b1, 10'h041, 8'h00, 8'h5A};
        vecs[7] = '{1'b0, 1'b1, 10'h100, 8'h00, 8'h77};

        lc_vecs[0] = '{8'h61, 8'h21};
        lc_vecs[1] = '{8'hC1, 8'h81};
        lc_vecs[2] = '{8'h41, 8'h41};
        lc_vecs[3] = '{8'h01, 8'h41};
        lc_vecs[4] = '{8'hFF, 8'hBF};
        lc_vecs[5] = '{8'h20, 8'h20};

        // Reset values
        repeat (3) tick();
        check("rst_a_vga_data", 32'(a_vga_data), 32'h00);
        check("rst_a_cpu_dout", 32'(a_cpu_dout), 32'h00);
        check("rst_a_busy", 32'(a_clr_busy), 32'h1);
        check("rst_b_busy", 32'(b_clr_busy), 32'h0);
        check("rst_b_cpu_dout", 32'(b_cpu_dout), 32'h00);
        check("rst_b_vga_data", 32'(b_vga_data), 32'h00);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Fill after reset lasts exactly 1024 cycles
        cyc = 0;
        while (a_clr_busy && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("reset_fill_len", 32'(cyc), 32'd1024);
        vga_a(10'h000, 8'h20);
        vga_a(10'h1FF, 8'h20);
        vga_a(10'h3FF, 8'h20);

        // CPU access table in IDLE
        for (int i = 0; i < 8; i++) begin
            a_cpu_wr   = vecs[i].wr;
            a_cpu_rd   = vecs[i].rd;
            a_cpu_addr = vecs[i].addr;
            a_cpu_din  = vecs[i].din;
            #1;
            check($sformatf("idle_wait_%0d", i), 32'(a_cpu_wait), 32'h0);
            sb_push($sformatf("cpu_dout_%0d", i), vecs[i].exp_dout);
            tick();
            a_cpu_wr = 1'b0;
            a_cpu_rd = 1'b0;
            sb_check(a_cpu_dout);
        end
        vga_a(10'h041, 8'h5A);
        vga_a(10'h3FF, 8'hA5);
        vga_a(10'h200, 8'h33);
        vga_a(10'h100, 8'h77);

        // clr_req then a CPU write held from fill cycle 100
        a_clr_req = 1'b1;
        #1;
        check("busy_before_req", 32'(a_clr_busy), 32'h0);
        tick();
        a_clr_req = 1'b0;
        check("busy_after_req", 32'(a_clr_busy), 32'h1);
        cyc = 0;
        wait_hi = 0;
        while (a_clr_busy && cyc < 3000) begin
            if (cyc == 100) begin
                a_cpu_wr   = 1'b1;
                a_cpu_addr = 10'h123;
                a_cpu_din  = 8'hC3;
                #1;
            end
            if (a_cpu_wr && a_cpu_wait) wait_hi++;
            tick();
            cyc++;
        end
        check("req_fill_len", 32'(cyc), 32'd1024);
        check("wait_hi_cycles", 32'(wait_hi), 32'd924);
        check("wait_low_idle", 32'(a_cpu_wait), 32'h0);
        tick();
        a_cpu_wr = 1'b0;
        vga_a(10'h123, 8'hC3);
        vga_a(10'h041, 8'h20);
        vga_a(10'h3FF, 8'h20);

        // clr_req with a same-cycle write, and a second clr_req mid-fill
        a_cpu_wr   = 1'b1;
        a_cpu_addr = 10'h000;
        a_cpu_din  = 8'h41;
        a_clr_req  = 1'b1;
        tick();
        a_cpu_wr  = 1'b0;
        a_clr_req = 1'b0;
        cyc = 0;
        while (a_clr_busy && cyc < 3000) begin
            a_clr_req = (cyc == 500);
            tick();
            cyc++;
        end
        a_clr_req = 1'b0;
        check("refire_fill_len", 32'(cyc), 32'd1024);
        vga_a(10'h000, 8'h20);
        vga_a(10'h123, 8'h20);

        // Reset during fill restarts it; video sweep runs alongside
        a_cpu_wr   = 1'b1;
        a_cpu_addr = 10'h2AA;
        a_cpu_din  = 8'h99;
        tick();
        a_cpu_wr = 1'b0;
        vga_a(10'h2AA, 8'h99);
        a_clr_req = 1'b1;
        tick();
        a_clr_req = 1'b0;
        repeat (300) tick();
        check("busy_at_300", 32'(a_clr_busy), 32'h1);
        rst_a = 1'b1;
        tick();
        check("midrst_cpu_dout", 32'(a_cpu_dout), 32'h00);
        check("midrst_vga_data", 32'(a_vga_data), 32'h00);
        rst_a = 1'b0;
        cyc = 0;
        while (a_clr_busy && cyc < 3000) begin
            sa = (cyc >= 32'h2A0 && cyc <= 32'h2B0) ? 10'h2AA : (10'(cyc) ^ 10'h155);
            se = (sa == 10'h2AA && cyc <= 32'h2AA) ? 8'h99 : 8'h20;
            a_vga_addr = sa;
            sb_push($sformatf("sweep_%0d", cyc), se);
            tick();
            sb_check(a_vga_data);
            cyc++;
        end
        check("rst_restart_len", 32'(cyc), 32'd1024);
        vga_a(10'h2AA, 8'h20);

        // 7-bit VRAM emulation
        for (int i = 0; i < 6; i++) begin
            b_cpu_wr   = 1'b1;
            b_cpu_addr = 10'(16 + i);
            b_cpu_din  = lc_vecs[i].din;
            tick();
            b_cpu_wr = 1'b0;
            b_cpu_rd = 1'b1;
            sb_push($sformatf("lc_cpu_%0h", lc_vecs[i].din), lc_vecs[i].exp);
            tick();
            b_cpu_rd = 1'b0;
            sb_check(b_cpu_dout);
            vga_b(10'(16 + i), lc_vecs[i].exp);
        end
        b_clr_req = 1'b1;
        tick();
        b_clr_req = 1'b0;
        cyc = 0;
        while (b_clr_busy && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("b_fill_len", 32'(cyc), 32'd1024);
        vga_b(10'h010, 8'h20);
        vga_b(10'h3FF, 8'h20);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
